// File: rtl/hack_data_memory_pkg.sv
// Shared types and address-map constants for the Hack data-memory responder.
package hack_mem_pkg;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_SCREEN,
    REG_KBD,
    REG_NONE
  } region_e;

  localparam int RAM_WORDS = 16384;
  localparam int SCR_BASE  = 16384;
  localparam int SCR_WORDS = 8192;
  localparam int KBD_ADDR  = 24576;

  localparam int ADDR_W   = 15;
  localparam int DATA_W   = 16;
  localparam int VID_AW   = 13;

  localparam logic [DATA_W-1:0] KEY_NEWLINE   = 16'd128;
  localparam logic [DATA_W-1:0] KEY_BACKSPACE = 16'd129;

endpackage

// File: rtl/hack_data_memory_if.sv
// CPU data bus, display read port and keyboard feed of the Hack data memory.
interface hack_data_memory_if;
  import hack_mem_pkg::*;

  logic [ADDR_W-1:0] addressM;
  logic              writeM;
  logic [DATA_W-1:0] outM;
  logic [DATA_W-1:0] inM;
  logic              vid_rd;
  logic [VID_AW-1:0] vid_addr;
  logic [DATA_W-1:0] vid_data;
  logic              vid_valid;
  logic              kbd_valid;
  logic [DATA_W-1:0] kbd_code;
  logic              bad_access;

  modport master (
    output addressM, writeM, outM, vid_rd, vid_addr, kbd_valid, kbd_code,
    input  inM, vid_data, vid_valid, bad_access
  );

  modport slave (
    input  addressM, writeM, outM, vid_rd, vid_addr, kbd_valid, kbd_code,
    output inM, vid_data, vid_valid, bad_access
  );

endinterface

// File: rtl/hack_data_memory_bram.sv
// Synchronous RAM: read/write port A and read-only port B, both read-before-write.
// Only the output registers are reset; array contents survive reset.
module hack_bram #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we_a,
  input  logic [AW-1:0]    addr_a,
  input  logic [WIDTH-1:0] wdata_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic             en_b,
  input  logic [AW-1:0]    addr_b,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_a_d, rdata_a_q;
  logic [WIDTH-1:0] rdata_b_d, rdata_b_q;

  always_comb begin
    rdata_a_d = mem_q[addr_a];
    rdata_b_d = en_b ? mem_q[addr_b] : rdata_b_q;
    if (reset) begin
      rdata_a_d = '0;
      rdata_b_d = '0;
    end
  end

  // Reads above sample the pre-edge array, so a same-cycle write is not visible yet.
  always_ff @(posedge clk) begin
    if (we_a && !reset) mem_q[addr_a] <= wdata_a;
    rdata_a_q <= rdata_a_d;
    rdata_b_q <= rdata_b_d;
  end

  assign rdata_a = rdata_a_q;
  assign rdata_b = rdata_b_q;

endmodule

// File: rtl/hack_data_memory.sv
// Hack CPU data memory: RAM, screen buffer and keyboard register behind the M bus,
// plus an independent display read port into the screen buffer.
module hack_data_memory #(
  parameter int RAM_WORDS = hack_mem_pkg::RAM_WORDS,
  parameter int SCR_BASE  = hack_mem_pkg::SCR_BASE,
  parameter int SCR_WORDS = hack_mem_pkg::SCR_WORDS,
  parameter int KBD_ADDR  = hack_mem_pkg::KBD_ADDR
) (
  input logic               clk,
  input logic               reset,
  hack_data_memory_if.slave bus
);
  import hack_mem_pkg::*;

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int SCR_AW = $clog2(SCR_WORDS);
  localparam logic [31:0] RAM_END_U  = 32'(RAM_WORDS);
  localparam logic [31:0] SCR_BASE_U = 32'(SCR_BASE);
  localparam logic [31:0] SCR_END_U  = 32'(SCR_BASE + SCR_WORDS);
  localparam logic [31:0] KBD_U      = 32'(KBD_ADDR);

  region_e           region, region_d, region_q;
  logic [31:0]       addr_w;
  logic [DATA_W-1:0] ram_rd, scr_rd, ram_rdb_unused;
  logic [DATA_W-1:0] kbd_d, kbd_q, kbd_rd_d, kbd_rd_q;
  logic              vid_valid_d, vid_valid_q;
  logic              bad_d, bad_q;
  logic [ADDR_W-1:0] addr_prev_d, addr_prev_q;

  assign addr_w = 32'(bus.addressM);

  // Decode is exact: nothing above the keyboard aliases back into RAM.
  always_comb begin
    region = REG_NONE;
    if (addr_w < RAM_END_U)                              region = REG_RAM;
    else if (addr_w >= SCR_BASE_U && addr_w < SCR_END_U) region = REG_SCREEN;
    else if (addr_w == KBD_U)                            region = REG_KBD;
  end

  hack_bram #(.DEPTH(RAM_WORDS), .WIDTH(DATA_W)) u_ram (
    .clk     (clk),
    .reset   (reset),
    .we_a    (bus.writeM && region == REG_RAM),
    .addr_a  (bus.addressM[RAM_AW-1:0]),
    .wdata_a (bus.outM),
    .rdata_a (ram_rd),
    .en_b    (1'b0),
    .addr_b  ('0),
    .rdata_b (ram_rdb_unused)
  );

  // Screen base is aligned to its size, so the low address bits are the word index.
  hack_bram #(.DEPTH(SCR_WORDS), .WIDTH(DATA_W)) u_screen (
    .clk     (clk),
    .reset   (reset),
    .we_a    (bus.writeM && region == REG_SCREEN),
    .addr_a  (bus.addressM[SCR_AW-1:0]),
    .wdata_a (bus.outM),
    .rdata_a (scr_rd),
    .en_b    (bus.vid_rd),
    .addr_b  (bus.vid_addr),
    .rdata_b (bus.vid_data)
  );

  always_comb begin
    region_d    = region;
    kbd_d       = bus.kbd_valid ? bus.kbd_code : kbd_q;
    kbd_rd_d    = (region == REG_KBD) ? kbd_q : '0;
    vid_valid_d = bus.vid_rd;
    bad_d       = bad_q;
    addr_prev_d = bus.addressM;
    if (region == REG_NONE && (bus.writeM || bus.addressM != addr_prev_q)) bad_d = 1'b1;
    if (reset) begin
      region_d    = REG_NONE;
      kbd_d       = '0;
      kbd_rd_d    = '0;
      vid_valid_d = 1'b0;
      bad_d       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    region_q    <= region_d;
    kbd_q       <= kbd_d;
    kbd_rd_q    <= kbd_rd_d;
    vid_valid_q <= vid_valid_d;
    bad_q       <= bad_d;
    addr_prev_q <= addr_prev_d;
  end

  // kbd_rd_q already carries zero for unmapped reads.
  always_comb begin
    case (region_q)
      REG_RAM:    bus.inM = ram_rd;
      REG_SCREEN: bus.inM = scr_rd;
      default:    bus.inM = kbd_rd_q;
    endcase
  end

  assign bus.vid_valid  = vid_valid_q;
  assign bus.bad_access = bad_q;

endmodule

// File: tb/tb_hack_data_memory.sv
// Directed and randomized checks of hack_data_memory against a word-level memory-map model.
module tb_hack_data_memory;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hack_data_memory_if bus ();

  hack_data_memory dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] m_ram [16384];
  bit          k_ram [16384];
  logic [15:0] m_scr [8192];
  bit          k_scr [8192];
  logic [15:0] m_kbd;
  logic        m_bad;
  int          m_prev;
  logic [15:0] e_inm, e_vd;
  bit          e_inm_k, e_vd_k;
  logic        e_vv;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model across the edge, compare outputs.
  task automatic step(input logic rst, input int a, input logic w, input logic [15:0] d,
                      input logic vr, input int va, input logic kv, input logic [15:0] kc);
    reset         = rst;
    bus.addressM  = 15'(a);
    bus.writeM    = w;
    bus.outM      = d;
    bus.vid_rd    = vr;
    bus.vid_addr  = 13'(va);
    bus.kbd_valid = kv;
    bus.kbd_code  = kc;
    @(posedge clk);
    if (rst) begin
      e_inm = 16'h0; e_inm_k = 1'b1;
      e_vd  = 16'h0; e_vd_k  = 1'b1;
      e_vv  = 1'b0;
      m_kbd = 16'h0;
      m_bad = 1'b0;
    end else begin
      e_inm_k = 1'b1;
      if (a < 16384) begin
        e_inm = m_ram[a]; e_inm_k = k_ram[a];
      end else if (a < 24576) begin
        e_inm = m_scr[a - 16384]; e_inm_k = k_scr[a - 16384];
      end else if (a == 24576) begin
        e_inm = m_kbd;
      end else begin
        e_inm = 16'h0;
      end
      e_vv = vr;
      if (vr) begin
        e_vd = m_scr[va]; e_vd_k = k_scr[va];
      end
      if (a > 24576 && (w || a != m_prev)) m_bad = 1'b1;
      if (w && a < 16384) begin
        m_ram[a] = d; k_ram[a] = 1'b1;
      end else if (w && a < 24576) begin
        m_scr[a - 16384] = d; k_scr[a - 16384] = 1'b1;
      end
      if (kv) m_kbd = kc;
    end
    m_prev = a;
    #1;
    if (e_inm_k) chk("inM", bus.inM, e_inm);
    chk("vid_valid", 16'(bus.vid_valid), 16'(e_vv));
    if (e_vd_k) chk("vid_data", bus.vid_data, e_vd);
    chk("bad_access", 16'(bus.bad_access), 16'(m_bad));
  endtask

  task automatic wr(input int a, input logic [15:0] d);
    step(1'b0, a, 1'b1, d, 1'b0, 0, 1'b0, 16'h0);
  endtask

  task automatic rd(input int a);
    step(1'b0, a, 1'b0, 16'h0, 1'b0, 0, 1'b0, 16'h0);
  endtask

  initial begin
    int a, va;
    m_kbd = 16'h0; m_bad = 1'b0; m_prev = 0;

    step(1'b1, 0, 1'b0, 16'h0, 1'b0, 0, 1'b0, 16'h0);
    step(1'b1, 0, 1'b0, 16'h0, 1'b1, 0, 1'b0, 16'h0);
    chk("rst_inM", bus.inM, 16'h0);
    chk("rst_vid_valid", 16'(bus.vid_valid), 16'h0);
    chk("rst_bad", 16'(bus.bad_access), 16'h0);

    // RAM write then read back
    wr(8, 16'hA5A5);
    wr(7, 16'h1234);
    rd(7);
    chk("ram_rd7", bus.inM, 16'h1234);
    rd(8);
    chk("ram_rd8", bus.inM, 16'hA5A5);

    // Screen: video read collides with CPU write
    wr(16384, 16'h0000);
    step(1'b0, 16384, 1'b1, 16'hFFFF, 1'b1, 0, 1'b0, 16'h0);
    chk("vid_collide_old", bus.vid_data, 16'h0000);
    step(1'b0, 0, 1'b0, 16'h0, 1'b1, 0, 1'b0, 16'h0);
    chk("vid_new", bus.vid_data, 16'hFFFF);
    chk("vid_valid_new", 16'(bus.vid_valid), 16'h1);
    rd(0);
    chk("vid_hold", bus.vid_data, 16'hFFFF);

    // Keyboard register
    step(1'b0, 0, 1'b0, 16'h0, 1'b0, 0, 1'b1, 16'd65);
    rd(24576);
    chk("kbd_65", bus.inM, 16'd65);
    step(1'b0, 24576, 1'b0, 16'h0, 1'b0, 0, 1'b1, 16'd0);
    chk("kbd_old_same_cycle", bus.inM, 16'd65);
    rd(24576);
    chk("kbd_0", bus.inM, 16'd0);
    wr(24576, 16'h0055);
    rd(24576);
    chk("kbd_cpu_write_ignored", bus.inM, 16'd0);

    // Unmapped access
    wr(1, 16'h0001);
    wr(24577, 16'hDEAD);
    chk("bad_set", 16'(bus.bad_access), 16'h1);
    rd(24577);
    chk("none_reads_0", bus.inM, 16'h0);
    rd(1);
    chk("no_alias", bus.inM, 16'h0001);
    chk("bad_sticky", 16'(bus.bad_access), 16'h1);

    // Read-before-write
    wr(3, 16'h3333);
    wr(3, 16'hBEEF);
    chk("rbw_old", bus.inM, 16'h3333);
    rd(3);
    chk("rbw_new", bus.inM, 16'hBEEF);

    // Reset in the middle of a write
    wr(5, 16'h5555);
    step(1'b0, 24576, 1'b0, 16'h0, 1'b0, 0, 1'b1, 16'd77);
    step(1'b1, 5, 1'b1, 16'hAAAA, 1'b1, 0, 1'b0, 16'h0);
    chk("rst_mid_inM", bus.inM, 16'h0);
    chk("rst_mid_vv", 16'(bus.vid_valid), 16'h0);
    chk("rst_mid_bad", 16'(bus.bad_access), 16'h0);
    rd(24576);
    chk("rst_mid_kbd", bus.inM, 16'h0);
    rd(5);
    chk("rst_mid_ram5", bus.inM, 16'h5555);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: a = int'($urandom_range(0, 15));
        4, 5, 6:    a = 16384 + int'($urandom_range(0, 15));
        7:          a = 24576;
        8:          a = int'($urandom_range(24577, 24580));
        default:    a = int'($urandom_range(24577, 32767));
      endcase
      va = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 8191)) : int'($urandom_range(0, 15));
      step(($urandom_range(0, 63) == 0), a, ($urandom_range(0, 2) == 0), 16'($urandom),
           ($urandom_range(0, 1) == 1), va, ($urandom_range(0, 5) == 0), 16'($urandom_range(0, 130)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
